// File: rtl/dpe_pkg.sv
// Shared constants and the accumulator add helper for the dot-product engine.
// The add helper reports signed overflow at an arbitrary width and optionally clamps.
package dpe_pkg;

  localparam int DEF_LANES = 64;
  localparam int DEF_IPREC = 8;
  localparam int DEF_OPREC = 32;

  typedef struct packed {
    logic        ovf;
    logic [63:0] val;
  } add_res_t;

  // Operands arrive sign-extended from `width` bits, so the 64-bit sum is exact.
  function automatic add_res_t acc_add(input longint a, input longint b,
                                       input int width, input bit sat);
    longint   sum;
    longint   hi;
    longint   lo;
    add_res_t r;
    sum   = a + b;
    hi    = (longint'(1) <<< (width - 1)) - 1;
    lo    = -hi - 1;
    r.ovf = (sum > hi) || (sum < lo);
    if (r.ovf && sat) r.val = (sum > hi) ? hi : lo;
    else              r.val = sum;
    return r;
  endfunction

endpackage

// File: rtl/dpe_acc_if.sv
// Beat-in / result-out handshake bundle for dpe_acc.
interface dpe_acc_if
  import dpe_pkg::*;
#(
  parameter int DATAW = DEF_LANES * DEF_IPREC,
  parameter int OPREC = DEF_OPREC
) ();

  logic             i_valid;
  logic             i_ready;
  logic             i_last;
  logic [DATAW-1:0] i_dataa;
  logic [DATAW-1:0] i_datab;
  logic             o_valid;
  logic             o_ready;
  logic [OPREC-1:0] o_result;
  logic             o_overflow;

  modport master (
    output i_valid, i_last, i_dataa, i_datab, o_ready,
    input  i_ready, o_valid, o_result, o_overflow
  );

  modport slave (
    input  i_valid, i_last, i_dataa, i_datab, o_ready,
    output i_ready, o_valid, o_result, o_overflow
  );

endinterface

// File: rtl/dpe_adder_tree.sv
// Pipelined pairwise reduction of LANES signed OPREC-bit values, one register per level.
// Level s adds element i with element i+N/2; valid/last ride alongside and all levels hold when en_i is low.
module dpe_adder_tree #(
  parameter int LANES = 64,
  parameter int OPREC = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   vld_i,
  input  logic                   last_i,
  input  logic [LANES*OPREC-1:0] dat_i,
  output logic                   vld_o,
  output logic                   last_o,
  output logic [OPREC-1:0]       sum_o
);

  localparam int LVLS = $clog2(LANES);

  for (genvar s = 0; s < LVLS; s++) begin : g_lvl
    localparam int N = LANES >> (s + 1);

    logic [OPREC-1:0] opnd [2*N];
    logic             op_vld;
    logic             op_last;
    logic [OPREC-1:0] sum_q [N];
    logic             vld_q;
    logic             last_q;

    if (s == 0) begin : g_first
      for (genvar i = 0; i < 2 * N; i++) begin : g_in
        assign opnd[i] = dat_i[i*OPREC +: OPREC];
      end
      assign op_vld  = vld_i;
      assign op_last = last_i;
    end else begin : g_next
      for (genvar i = 0; i < 2 * N; i++) begin : g_in
        assign opnd[i] = g_lvl[s-1].sum_q[i];
      end
      assign op_vld  = g_lvl[s-1].vld_q;
      assign op_last = g_lvl[s-1].last_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
        for (int i = 0; i < N; i++) sum_q[i] <= '0;
      end else if (en_i) begin
        vld_q  <= op_vld;
        last_q <= op_last;
        for (int i = 0; i < N; i++) sum_q[i] <= opnd[i] + opnd[i+N];
      end
    end
  end

  assign vld_o  = g_lvl[LVLS-1].vld_q;
  assign last_o = g_lvl[LVLS-1].last_q;
  assign sum_o  = g_lvl[LVLS-1].sum_q[0];

endmodule

// File: rtl/dpe_acc.sv
// Streaming signed dot-product accumulator: input reg, lane multiply, adder tree, accumulate.
// A result appears 3+clog2(LANES) cycles after its last beat; a held result stalls every stage.
module dpe_acc
  import dpe_pkg::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int IPREC    = DEF_IPREC,
  parameter int MPREC    = 2 * IPREC,
  parameter int OPREC    = DEF_OPREC,
  parameter int DATAW    = LANES * IPREC,
  parameter int SATURATE = 0
) (
  input logic      clk,
  input logic      rst,
  dpe_acc_if.slave bus
);

  logic                   en;

  logic                   in_vld_q;
  logic                   in_last_q;
  logic [DATAW-1:0]       a_q;
  logic [DATAW-1:0]       b_q;

  logic [MPREC-1:0]       mul_d [LANES];
  logic [MPREC-1:0]       mul_q [LANES];
  logic                   mul_vld_q;
  logic                   mul_last_q;

  logic [LANES*OPREC-1:0] tree_in;
  logic                   t_vld;
  logic                   t_last;
  logic [OPREC-1:0]       t_sum;

  add_res_t               add_r;
  logic [OPREC-1:0]       acc_d, acc_q;
  logic                   ovf_d, ovf_q;
  logic                   first_d, first_q;
  logic [OPREC-1:0]       out_res_d, out_res_q;
  logic                   out_ovf_d, out_ovf_q;
  logic                   out_vld_d, out_vld_q;

  // The only source of backpressure is an unaccepted result.
  assign en          = !(out_vld_q && !bus.o_ready);
  assign bus.i_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_vld_q  <= 1'b0;
      in_last_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else if (en) begin
      in_vld_q  <= bus.i_valid;
      in_last_q <= bus.i_valid && bus.i_last;
      a_q       <= bus.i_dataa;
      b_q       <= bus.i_datab;
    end
  end

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      mul_d[j] = MPREC'(signed'(a_q[j*IPREC +: IPREC])) * MPREC'(signed'(b_q[j*IPREC +: IPREC]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_vld_q  <= 1'b0;
      mul_last_q <= 1'b0;
      for (int j = 0; j < LANES; j++) mul_q[j] <= '0;
    end else if (en) begin
      mul_vld_q  <= in_vld_q;
      mul_last_q <= in_last_q;
      for (int j = 0; j < LANES; j++) mul_q[j] <= mul_d[j];
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_sext
    assign tree_in[j*OPREC +: OPREC] = {{(OPREC-MPREC){mul_q[j][MPREC-1]}}, mul_q[j]};
  end

  dpe_adder_tree #(
    .LANES (LANES),
    .OPREC (OPREC)
  ) u_tree (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en),
    .vld_i  (mul_vld_q),
    .last_i (mul_last_q),
    .dat_i  (tree_in),
    .vld_o  (t_vld),
    .last_o (t_last),
    .sum_o  (t_sum)
  );

  always_comb begin
    add_r     = acc_add(longint'(signed'(acc_q)), longint'(signed'(t_sum)), OPREC, SATURATE != 0);
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    first_d   = first_q;
    out_res_d = out_res_q;
    out_ovf_d = out_ovf_q;
    out_vld_d = out_vld_q;
    if (en) begin
      out_vld_d = 1'b0;
      if (t_vld) begin
        // A vector's first beat loads rather than adds, which also clears the sticky flag.
        if (first_q) begin
          acc_d = t_sum;
          ovf_d = 1'b0;
        end else begin
          acc_d = OPREC'(add_r.val);
          ovf_d = ovf_q | add_r.ovf;
        end
        first_d = t_last;
        if (t_last) begin
          out_res_d = acc_d;
          out_ovf_d = ovf_d;
          out_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      first_q   <= 1'b1;
      out_res_q <= '0;
      out_ovf_q <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      first_q   <= first_d;
      out_res_q <= out_res_d;
      out_ovf_q <= out_ovf_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign bus.o_valid    = out_vld_q;
  assign bus.o_result   = out_res_q;
  assign bus.o_overflow = out_ovf_q;

endmodule

// File: tb/tb_dpe_acc.sv
// Scoreboard bench: a wrapping 32-bit instance and a saturating 24-bit instance see identical traffic.
// The reference model works on whole-vector integer dot products; a negedge monitor pops and compares.
module tb_dpe_acc;

  localparam int LANES = 64;
  localparam int IPREC = 8;
  localparam int DATAW = LANES * IPREC;
  localparam int LAT   = 3 + $clog2(LANES);

  typedef struct {
    longint res;
    bit     ovf;
    int     cyc;
    bit     chk_lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             drv_valid = 1'b0;
  logic             drv_last  = 1'b0;
  logic [DATAW-1:0] drv_a = '0;
  logic [DATAW-1:0] drv_b = '0;
  logic             drv_ordy = 1'b1;
  bit               rand_rdy = 1'b0;
  bit               force_rdy = 1'b1;

  int     cyc = 0;
  int     n_chk = 0;
  int     n_fail = 0;
  exp_t   exp0[$];
  exp_t   exp1[$];
  longint m_acc[2];
  bit     m_ovf[2];
  bit     m_first[2];
  bit     hold[2];
  longint hres[2];
  bit     hovf[2];
  longint last_res[2];
  bit     last_ovf[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dpe_acc_if #(.DATAW(DATAW), .OPREC(32)) bus0 ();
  dpe_acc_if #(.DATAW(DATAW), .OPREC(24)) bus1 ();

  assign bus0.i_valid = drv_valid;
  assign bus0.i_last  = drv_last;
  assign bus0.i_dataa = drv_a;
  assign bus0.i_datab = drv_b;
  assign bus0.o_ready = drv_ordy;
  assign bus1.i_valid = drv_valid;
  assign bus1.i_last  = drv_last;
  assign bus1.i_dataa = drv_a;
  assign bus1.i_datab = drv_b;
  assign bus1.o_ready = drv_ordy;

  dpe_acc #(.LANES(LANES), .IPREC(IPREC), .OPREC(32), .SATURATE(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  dpe_acc #(.LANES(LANES), .IPREC(IPREC), .OPREC(24), .SATURATE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DATAW-1:0] fill(input int v);
    logic [DATAW-1:0] r;
    for (int j = 0; j < LANES; j++) r[j*IPREC +: IPREC] = IPREC'(v);
    return r;
  endfunction

  function automatic logic [DATAW-1:0] rnd_vec();
    logic [DATAW-1:0] r;
    for (int j = 0; j < LANES; j++) r[j*IPREC +: IPREC] = IPREC'($urandom);
    return r;
  endfunction

  // Reference: integer dot product per beat, then per-configuration accumulate rules.
  task automatic model_beat(input logic [DATAW-1:0] a, input logic [DATAW-1:0] b,
                            input bit last, input bit chk_lat);
    longint dot;
    longint s;
    longint hi;
    longint lo;
    int     w;
    exp_t   e;
    dot = 0;
    for (int j = 0; j < LANES; j++)
      dot += longint'($signed(a[j*IPREC +: IPREC])) * longint'($signed(b[j*IPREC +: IPREC]));
    for (int k = 0; k < 2; k++) begin
      w  = (k == 0) ? 32 : 24;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -hi - 1;
      if (m_first[k]) begin
        m_acc[k] = dot;
        m_ovf[k] = 1'b0;
      end else begin
        s = m_acc[k] + dot;
        if (s > hi || s < lo) begin
          m_ovf[k] = 1'b1;
          if (k == 1) s = (s > hi) ? hi : lo;
          else        s = (s > hi) ? s - (longint'(1) <<< w) : s + (longint'(1) <<< w);
        end
        m_acc[k] = s;
      end
      m_first[k] = last;
      if (last) begin
        e = '{m_acc[k], m_ovf[k], cyc, chk_lat};
        if (k == 0) exp0.push_back(e);
        else        exp1.push_back(e);
      end
    end
  endtask

  task automatic mon(input int k, input logic vld, input logic ordy,
                     input logic signed [63:0] res, input logic ovf);
    exp_t e;
    bit   have;
    if (hold[k]) begin
      chk(k == 0 ? "hold_vld0" : "hold_vld1", 64'(vld), 1);
      chk(k == 0 ? "hold_res0" : "hold_res1", res, hres[k]);
      chk(k == 0 ? "hold_ovf0" : "hold_ovf1", 64'(ovf), 64'(hovf[k]));
    end
    if (vld && ordy) begin
      have = (k == 0) ? (exp0.size() != 0) : (exp1.size() != 0);
      if (!have) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result%0d: got %0d, expected no result", k, res);
      end else begin
        if (k == 0) e = exp0.pop_front();
        else        e = exp1.pop_front();
        chk(k == 0 ? "result0" : "result1", res, e.res);
        chk(k == 0 ? "overflow0" : "overflow1", 64'(ovf), 64'(e.ovf));
        if (e.chk_lat) chk(k == 0 ? "latency0" : "latency1", 64'(cyc - e.cyc), LAT);
        last_res[k] = res;
        last_ovf[k] = ovf;
      end
    end
    hold[k] = vld && !ordy;
    hres[k] = res;
    hovf[k] = ovf;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold[0] = 1'b0;
        hold[1] = 1'b0;
      end else begin
        chk("i_ready_rule", 64'(bus0.i_ready), 64'(!(bus0.o_valid && !bus0.o_ready)));
        mon(0, bus0.o_valid, bus0.o_ready, $signed(bus0.o_result), bus0.o_overflow);
        mon(1, bus1.o_valid, bus1.o_ready, $signed(bus1.o_result), bus1.o_overflow);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      drv_ordy = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DATAW-1:0] a, input logic [DATAW-1:0] b,
                      input bit last, input bit chk_lat);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    drv_valid = 1'b1;
    drv_last  = last;
    drv_a     = a;
    drv_b     = b;
    while (!done) begin
      @(negedge clk);
      if (bus0.i_ready) begin
        model_beat(a, b, last, chk_lat);
        done = 1'b1;
      end else if (++t > 300) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: got i_ready=0 for %0d cycles, expected acceptance", t);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    drv_valid = 1'b0;
    drv_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && t < 400) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_pending", 64'(exp0.size() + exp1.size()), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv_valid = 1'b0;
    exp0.delete();
    exp1.delete();
    for (int k = 0; k < 2; k++) begin
      m_first[k] = 1'b1;
      m_acc[k]   = 0;
      m_ovf[k]   = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ovalid0", 64'(bus0.o_valid), 0);
    chk("rst_result0", 64'(bus0.o_result), 0);
    chk("rst_ovf0", 64'(bus0.o_overflow), 0);
    chk("rst_iready0", 64'(bus0.i_ready), 1);
    chk("rst_ovalid1", 64'(bus1.o_valid), 0);
    chk("rst_result1", 64'(bus1.o_result), 0);
    chk("rst_ovf1", 64'(bus1.o_overflow), 0);
    chk("rst_iready1", 64'(bus1.i_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int t0;
    int nb;
    do_reset();

    // Single beat of ones, latency measured exactly.
    send(fill(1), fill(1), 1'b1, 1'b1);
    drain();
    chk("single_res", last_res[0], 64);
    chk("single_ovf", 64'(last_ovf[0]), 0);

    for (int i = 0; i < 3; i++) send(fill(-128), fill(-128), i == 2, 1'b0);
    drain();
    chk("three_beat_res", last_res[0], 3145728);
    chk("three_beat_ovf", 64'(last_ovf[0]), 0);

    // Nine beats of 2^20 each overflow the 24-bit accumulator only.
    for (int i = 0; i < 9; i++) send(fill(-128), fill(-128), i == 8, 1'b0);
    drain();
    chk("sat_res", last_res[1], 8388607);
    chk("sat_ovf", 64'(last_ovf[1]), 1);
    chk("wide_res", last_res[0], 9437184);
    send(fill(1), fill(1), 1'b1, 1'b0);
    drain();
    chk("after_sat_res", last_res[1], 64);
    chk("after_sat_ovf", 64'(last_ovf[1]), 0);

    // Downstream stall with two results in flight.
    force_rdy = 1'b0;
    idle(2);
    send(fill(1), fill(1), 1'b1, 1'b0);
    send(fill(2), fill(1), 1'b1, 1'b0);
    idle(16);
    chk("stall_iready", 64'(bus0.i_ready), 0);
    chk("stall_ovalid", 64'(bus0.o_valid), 1);
    chk("stall_res", $signed(bus0.o_result), 64);
    force_rdy = 1'b1;
    drain();
    chk("stall_second_res", last_res[0], 128);

    // Reset in the middle of a vector discards the partial sum.
    send(fill(5), fill(5), 1'b0, 1'b0);
    send(fill(5), fill(5), 1'b0, 1'b0);
    do_reset();
    send(fill(2), fill(2), 1'b1, 1'b0);
    drain();
    chk("post_rst_res", last_res[0], 256);

    // Back-to-back single-beat vectors at full rate.
    t0 = cyc;
    for (int k = 1; k <= 20; k++) send(fill(k), fill(1), 1'b1, 1'b0);
    chk("stream_cycles", 64'(cyc - t0), 20);
    drain();
    chk("stream_last_res", last_res[0], 1280);

    // Random vectors, gaps and downstream backpressure.
    rand_rdy = 1'b1;
    for (int v = 0; v < 40; v++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        send(rnd_vec(), rnd_vec(), b == nb - 1, 1'b0);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    rand_rdy = 1'b0;
    idle(2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dpe_acc.md
DPE_ACC -- requirements
Module: dpe_acc

Interface
REQ-001 The block SHALL have parameter LANES, default 64, meaning elements per beat; it SHALL be a power of two, 2..256.
REQ-002 The block SHALL have parameter IPREC, default 8, meaning signed input element width.
REQ-003 The block SHALL have parameter MPREC, default 2*IPREC, meaning product width.
REQ-004 The block SHALL have parameter OPREC, default 32, meaning tree/accumulator/result width; OPREC SHALL be >= MPREC+clog2(LANES).
REQ-005 The block SHALL have parameter DATAW, default LANES*IPREC, meaning input vector bus width.
REQ-006 The block SHALL have parameter SATURATE, default 0, meaning 1 = clamp accumulator, 0 = two's-complement wrap.
REQ-007 The block SHALL have port clk, input, 1 bit: clock; all logic on posedge.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 The block SHALL have port i_valid, input, 1 bit: input beat valid.
REQ-010 The block SHALL have port i_ready, output, 1 bit: block accepts beat this cycle.
REQ-011 The block SHALL have port i_last, input, 1 bit: beat is final chunk of current vector.
REQ-012 The block SHALL have ports i_dataa and i_datab, input, DATAW bits each: lane j at bits [(j+1)*IPREC-1 : j*IPREC], signed.
REQ-013 The block SHALL have port o_valid, output, 1 bit: result valid.
REQ-014 The block SHALL have port o_ready, input, 1 bit: downstream accepts result.
REQ-015 The block SHALL have port o_result, output, OPREC bits: signed dot product of full vector.
REQ-016 The block SHALL have port o_overflow, output, 1 bit: sticky flag, set if any accumulate of this vector saturated or wrapped.

Function
REQ-017 A beat SHALL be accepted when i_valid && i_ready; a result SHALL be transferred when o_valid && o_ready.
REQ-018 i_ready SHALL equal !(o_valid && !o_ready); when low, every pipeline stage SHALL hold.
REQ-019 Pipeline SHALL be: input register (1), lane multiply IPREC x IPREC signed to MPREC (1), adder tree clog2(LANES) stages, accumulate/output register (1).
REQ-020 Latency from accepting an i_last beat to o_valid, absent stalls, SHALL be 3+clog2(LANES) cycles (9 at LANES=64).
REQ-021 Products SHALL be sign-extended to OPREC before the tree; each tree stage SHALL add pairs (i, i+N/2) and register.
REQ-022 A valid flag SHALL travel with each beat, together with its last flag, through every stage.
REQ-023 The first beat after reset, or after a last beat, SHALL load acc = tree_sum; any other beat SHALL load acc = acc + tree_sum.
REQ-024 With SATURATE=1, acc SHALL clamp to [-2^(OPREC-1), 2^(OPREC-1)-1]; with SATURATE=0 it SHALL wrap.
REQ-025 o_overflow SHALL be set on signed overflow of the acc add, held for the remainder of the vector, and cleared at the next vector start.
REQ-026 When the last beat reaches the accumulate stage, o_result/o_overflow SHALL take the final value and o_valid SHALL assert.
REQ-027 o_result and o_overflow SHALL be held stable while o_valid && !o_ready.
REQ-028 A single-beat vector (i_last on its first beat) SHALL be legal; back-to-back i_last beats SHALL yield one result per cycle.
REQ-029 Beats with i_valid=0 SHALL NOT alter acc; gaps inside a vector SHALL be legal.
REQ-030 Unused lanes SHALL be zero-driven by the source; the block SHALL NOT mask lanes.

Reset
REQ-031 On rst, all data/valid pipeline registers, acc, o_result, o_overflow and o_valid SHALL clear to 0, and i_ready SHALL be 1 in the following cycle.
REQ-032 rst mid-vector SHALL discard the partial accumulation; the next accepted beat SHALL start a new vector.
REQ-033 rst SHALL take priority over stall and handshake.

Structure
REQ-034 Shared package dpe_pkg SHALL hold default LANES/IPREC/OPREC constants and the saturating-add function.
REQ-035 The pipelined reduction SHALL be sub-module dpe_adder_tree, parametrised by LANES and OPREC, with an enable input.

Verification (LANES=64, IPREC=8)
REQ-036 One beat, all lanes a=1 b=1, i_last=1 -> o_result=64, o_overflow=0, o_valid exactly 9 cycles after accept.
REQ-037 Three beats, all lanes a=-128 b=-128, i_last on third -> o_result=3145728, o_overflow=0.
REQ-038 OPREC=24, SATURATE=1, nine beats all lanes -128*-128 -> o_result=8388607, o_overflow=1; the next vector of one beat all 1s -> 64, o_overflow=0.
REQ-039 Two single-beat vectors (results 64 and 128) with o_ready=0 for 10 cycles -> first result held stable, i_ready=0, then on o_ready=1 results are delivered in order with no loss.
REQ-040 Two beats all 5s without last, rst, then one beat all a=2 b=2 with last -> o_result=256.
REQ-041 Continuous i_valid, i_last every beat, lane values a=k b=1 on beat k -> one result per cycle equal to 64*k.
